// File: rtl/shuttle_vehicle_if.sv
// shuttle_vehicle_if: mission-controller command/status bundle for the shuttle vehicle
interface shuttle_vehicle_if;
  logic        systems_ok;
  logic        start_countdown;
  logic        launch_shuttle;
  logic        start_trip_meter;
  logic        land_shuttle;
  logic        all_systems_go;
  logic [3:0]  cnt;
  logic        just_launched;
  logic        is_landed;
  logic [15:0] trip_meter;
  logic        seq_error;
  modport master (
    output systems_ok, start_countdown, launch_shuttle, start_trip_meter, land_shuttle,
    input  all_systems_go, cnt, just_launched, is_landed, trip_meter, seq_error
  );
  modport slave (
    input  systems_ok, start_countdown, launch_shuttle, start_trip_meter, land_shuttle,
    output all_systems_go, cnt, just_launched, is_landed, trip_meter, seq_error
  );
endinterface

// File: rtl/shuttle_vehicle.sv
// shuttle_vehicle: mission FSM (preflight, countdown, ascent, orbit, descent, landed) with trip meter
module shuttle_vehicle #(
  parameter int         PREFLIGHT_CYCLES = 4,
  parameter logic [3:0] COUNT_START      = 4'd9,
  parameter int         ASCENT_CYCLES    = 3,
  parameter int         LAND_CYCLES      = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  shuttle_vehicle_if.slave bus
);
  typedef enum logic [2:0] {IDLE, COUNTDOWN, ASCENT, ORBIT, DESCENT, LANDED} state_e;
  localparam logic [3:0] PRE_MAX  = 4'(PREFLIGHT_CYCLES);
  localparam logic [3:0] ASC_MAX  = 4'(ASCENT_CYCLES);
  localparam logic [3:0] LAND_MAX = 4'(LAND_CYCLES);
  state_e      state_q, state_d;
  logic [3:0]  pre_q, pre_d, asc_q, asc_d, desc_q, desc_d, cnt_q, cnt_d;
  logic        asg_q, asg_d, jl_q, jl_d, landed_q, landed_d, err_q, err_d;
  logic [15:0] trip_q, trip_d;
  logic        ld, la, st;
  assign ld = bus.land_shuttle;
  assign la = bus.launch_shuttle;
  assign st = bus.start_countdown;
  always_comb begin
    state_d  = state_q;
    pre_d    = 4'd0;
    asc_d    = asc_q;
    desc_d   = desc_q;
    cnt_d    = cnt_q;
    jl_d     = jl_q;
    landed_d = landed_q;
    err_d    = err_q;
    trip_d   = ((state_q == ASCENT || state_q == ORBIT) && bus.start_trip_meter && trip_q != 16'hFFFF)
               ? trip_q + 16'd1 : trip_q;
    case (state_q)
      IDLE: begin
        pre_d = !bus.systems_ok ? 4'd0 : (pre_q == PRE_MAX ? pre_q : pre_q + 4'd1);
        if (ld) begin
          state_d  = LANDED;
          landed_d = 1'b1;
          pre_d    = 4'd0;
        end else if (la) begin
          err_d = 1'b1;
        end else if (st && asg_q) begin
          state_d = COUNTDOWN;
          cnt_d   = COUNT_START;
          trip_d  = 16'd0;
          pre_d   = 4'd0;
        end else if (st) begin
          err_d = 1'b1;
        end
      end
      COUNTDOWN: begin
        if (bus.systems_ok && cnt_q != 4'd0 && !ld) cnt_d = cnt_q - 4'd1;
        if (ld) begin
          state_d = DESCENT;
          desc_d  = 4'd0;
          jl_d    = 1'b0;
        end else if (la && cnt_q == 4'd0) begin
          state_d = ASCENT;
          jl_d    = 1'b1;
          asc_d   = 4'd1;
        end else if (la || st) begin
          err_d = 1'b1;
        end
      end
      ASCENT, ORBIT: begin
        if (ld) begin
          state_d = DESCENT;
          desc_d  = 4'd0;
          jl_d    = 1'b0;
        end else begin
          if (la || st) err_d = 1'b1;
          if (state_q == ASCENT && asc_q == ASC_MAX) begin
            state_d = ORBIT;
            jl_d    = 1'b0;
          end else if (state_q == ASCENT) begin
            asc_d = asc_q + 4'd1;
          end
        end
      end
      DESCENT: begin
        if (ld && desc_q + 4'd1 == LAND_MAX) begin
          state_d  = LANDED;
          landed_d = 1'b1;
          desc_d   = 4'd0;
        end else if (ld) begin
          desc_d = desc_q + 4'd1;
        end else if (la) begin
          err_d = 1'b1;
        end
      end
      LANDED: begin
        if (!ld && la) begin
          err_d = 1'b1;
        end else if (!ld && !st) begin
          state_d  = IDLE;
          landed_d = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        jl_d     = 1'b0;
        landed_d = 1'b0;
        asc_d    = 4'd0;
        desc_d   = 4'd0;
      end
    endcase
    asg_d = (state_d == IDLE) && (pre_d == PRE_MAX);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      pre_q    <= 4'd0;
      asc_q    <= 4'd0;
      desc_q   <= 4'd0;
      cnt_q    <= 4'd0;
      asg_q    <= 1'b0;
      jl_q     <= 1'b0;
      landed_q <= 1'b0;
      err_q    <= 1'b0;
      trip_q   <= 16'd0;
    end else begin
      state_q  <= state_d;
      pre_q    <= pre_d;
      asc_q    <= asc_d;
      desc_q   <= desc_d;
      cnt_q    <= cnt_d;
      asg_q    <= asg_d;
      jl_q     <= jl_d;
      landed_q <= landed_d;
      err_q    <= err_d;
      trip_q   <= trip_d;
    end
  end
  assign bus.all_systems_go = asg_q;
  assign bus.cnt            = cnt_q;
  assign bus.just_launched  = jl_q;
  assign bus.is_landed      = landed_q;
  assign bus.trip_meter     = trip_q;
  assign bus.seq_error      = err_q;
endmodule
